bcd_bin_seq: RTL and testbench



---
 rtl/bcd_bin_seq_if.sv | 17 +
 rtl/bcd_bin_seq.sv | 82 ++++++++
 tb/tb_bcd_bin_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_bin_seq_if.sv
// bcd_bin_seq_if: valid/ready operand and result bus for the iterative BCD/binary converter
interface bcd_bin_seq_if #(
  parameter int DECLEN = 9,
  parameter int BINLEN = 30
);
  logic in_valid, in_ready, mode, out_valid, out_ready, ovf, bad_digit;
  logic [DECLEN*4-1:0] bcd_in, bcd_out;
  logic [BINLEN-1:0] bin_in, bin_out;
  modport master (
    output in_valid, mode, bcd_in, bin_in, out_ready,
    input  in_ready, out_valid, bin_out, bcd_out, ovf, bad_digit
  );
  modport slave (
    input  in_valid, mode, bcd_in, bin_in, out_ready,
    output in_ready, out_valid, bin_out, bcd_out, ovf, bad_digit
  );
endinterface

// File: rtl/bcd_bin_seq.sv
// bcd_bin_seq: iterative BCD->binary (digit MAC) / binary->BCD (double dabble) converter
module bcd_bin_seq #(
  parameter int DECLEN = 9,
  parameter int BINLEN = 30
) (
  input logic         clk,
  input logic         rst_n,
  bcd_bin_seq_if.slave bus
);
  localparam int DW = DECLEN * 4;
  localparam int MW = BINLEN + 4;
  localparam int MX = DECLEN > BINLEN ? DECLEN : BINLEN;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state;
  logic r_mode, r_ovf, r_bad;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_bcd_sh, r_dd, r_bcd_out;
  logic [BINLEN-1:0] r_acc, r_bin_sh, r_bin_out;
  logic [3:0] w_dig;
  logic [MW-1:0] w_mac;
  logic [DW-1:0] w_adj, w_dd;
  logic w_last;
  assign w_dig  = r_bcd_sh[DW-1 -: 4];
  assign w_mac  = MW'(r_acc) * MW'(10) + MW'(w_dig);
  // double dabble: add 3 to every digit >= 5, then shift {bcd,bin} left by one
  for (genvar g = 0; g < DECLEN; g++) begin : g_adj
    assign w_adj[4*g +: 4] = r_dd[4*g +: 4] >= 4'd5 ? r_dd[4*g +: 4] + 4'd3 : r_dd[4*g +: 4];
  end
  assign w_dd   = {w_adj[DW-2:0], r_bin_sh[BINLEN-1]};
  assign w_last = r_cnt == (r_mode ? CW'(BINLEN - 1) : CW'(DECLEN - 1));
  assign bus.in_ready  = r_state == IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.bin_out   = r_bin_out;
  assign bus.bcd_out   = r_bcd_out;
  assign bus.ovf       = r_ovf;
  assign bus.bad_digit = r_bad;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mode    <= 1'b0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_bad     <= 1'b0;
      r_acc     <= '0;
      r_dd      <= '0;
      r_bcd_sh  <= '0;
      r_bin_sh  <= '0;
      r_bin_out <= '0;
      r_bcd_out <= '0;
    end else if (r_state == IDLE) begin
      if (bus.in_valid) begin
        r_state  <= RUN;
        r_mode   <= bus.mode;
        r_cnt    <= '0;
        r_ovf    <= 1'b0;
        r_bad    <= 1'b0;
        r_acc    <= '0;
        r_dd     <= '0;
        r_bcd_sh <= bus.bcd_in;
        r_bin_sh <= bus.bin_in;
      end
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_mode) begin
        r_dd     <= w_dd;
        r_bin_sh <= r_bin_sh << 1;
        r_ovf    <= r_ovf | w_adj[DW-1];
        if (w_last) r_bcd_out <= w_dd;
      end else begin
        r_acc    <= w_mac[BINLEN-1:0];
        r_bcd_sh <= r_bcd_sh << 4;
        r_ovf    <= r_ovf | (|w_mac[MW-1:BINLEN]);
        r_bad    <= r_bad | (w_dig > 4'd9);
        if (w_last) r_bin_out <= w_mac[BINLEN-1:0];
      end
      if (w_last) r_state <= DONE;
    end else if (bus.out_ready) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_bcd_bin_seq.sv
// tb_bcd_bin_seq: scoreboard bench for two converter instances (3 and 4 digits, 10-bit binary)
module tb_bcd_bin_seq;
  typedef struct {
    logic [9:0]  bin;
    logic [15:0] bcd;
    logic        ovf;
    logic        bad;
    int          t;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bp = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[2][$];
  exp_t cur[2];
  logic hold[2] = '{1'b0, 1'b0};
  logic hs[2] = '{1'b0, 1'b0};
  logic [9:0]  last_bin[2] = '{10'd0, 10'd0};
  logic [15:0] last_bcd[2] = '{16'd0, 16'd0};

  bcd_bin_seq_if #(.DECLEN(3), .BINLEN(10)) ia();
  bcd_bin_seq_if #(.DECLEN(4), .BINLEN(10)) ib();
  bcd_bin_seq #(.DECLEN(3), .BINLEN(10)) ua(.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  bcd_bin_seq #(.DECLEN(4), .BINLEN(10)) ub(.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string n);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", n, cyc);
  endtask

  // Reference: plain decimal arithmetic on the operand, independent of step-level behaviour
  function automatic exp_t model(input int k, input logic m, input logic [15:0] bcd, input logic [9:0] bin);
    exp_t e;
    int d;
    longint v;
    longint p;
    e = '{default: 0};
    d = k ? 4 : 3;
    v = 0;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (!m) begin
      for (int i = d - 1; i >= 0; i--) begin
        int dg;
        dg = int'((bcd >> (4 * i)) & 16'hF);
        e.bad = e.bad | (dg > 9);
        v = v * 10 + dg;
      end
      e.bin = 10'(v % 1024);
      e.ovf = v >= 1024;
      e.bcd = last_bcd[k];
      e.lat = d;
      last_bin[k] = e.bin;
    end else begin
      v = longint'(bin) % p;
      for (int i = 0; i < d; i++) begin
        e.bcd[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
      e.ovf = longint'(bin) >= p;
      e.bin = last_bin[k];
      e.lat = 10;
      last_bcd[k] = e.bcd;
    end
    return e;
  endfunction

  task automatic drive(input int k, input logic v, input logic m, input logic [15:0] bcd, input logic [9:0] bin);
    if (k == 0) begin
      ia.in_valid = v; ia.mode = m; ia.bcd_in = bcd[11:0]; ia.bin_in = bin;
    end else begin
      ib.in_valid = v; ib.mode = m; ib.bcd_in = bcd; ib.bin_in = bin;
    end
  endtask

  function automatic logic rdy(input int k);
    return k ? ib.in_ready : ia.in_ready;
  endfunction

  task automatic send(input int k, input logic m, input logic [15:0] bcd, input logic [9:0] bin);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    drive(k, 1'b1, m, bcd, bin);
    while (!rdy(k) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(k)) fail_now($sformatf("send_timeout%0d", k));
    else begin
      e = model(k, m, bcd, bin);
      e.t = cyc + 1;
      q[k].push_back(e);
    end
    @(posedge clk);
    #1 drive(k, 1'b0, 1'b0, 16'd0, 10'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0 || !ia.in_ready || !ib.in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail_now("idle_timeout");
  endtask

  task automatic rst_chk(input int k, input logic ir, input logic ov, input logic [9:0] bo,
                         input logic [15:0] co, input logic of, input logic bd);
    chk($sformatf("rst_in_ready%0d", k), ir, 1);
    chk($sformatf("rst_out_valid%0d", k), ov, 0);
    chk($sformatf("rst_bin_out%0d", k), bo, 0);
    chk($sformatf("rst_bcd_out%0d", k), co, 0);
    chk($sformatf("rst_ovf%0d", k), of, 0);
    chk($sformatf("rst_bad%0d", k), bd, 0);
  endtask

  task automatic mon(input int k, input logic ov, input logic ordy, input logic ir, input logic [9:0] bo,
                     input logic [15:0] co, input logic of, input logic bd);
    if (!rst_n) begin
      hold[k] = 1'b0;
      hs[k] = 1'b0;
    end else begin
      if (hs[k]) chk($sformatf("in_ready_after_out%0d", k), ir, 1);
      if (ov) begin
        if (!hold[k]) begin
          if (q[k].size() == 0) begin
            fail_now($sformatf("unexpected_out%0d bin=%0h bcd=%0h", k, bo, co));
            cur[k] = '{bin: bo, bcd: co, ovf: of, bad: bd, t: 0, lat: 0};
          end else begin
            cur[k] = q[k].pop_front();
            chk($sformatf("latency%0d", k), cyc - cur[k].t, cur[k].lat);
          end
        end
        chk($sformatf("bin_out%0d", k), bo, cur[k].bin);
        chk($sformatf("bcd_out%0d", k), co, cur[k].bcd);
        chk($sformatf("ovf%0d", k), of, cur[k].ovf);
        chk($sformatf("bad_digit%0d", k), bd, cur[k].bad);
        chk($sformatf("in_ready_busy%0d", k), ir, 0);
      end
      hold[k] = ov && !ordy;
      hs[k] = ov && ordy;
    end
  endtask

  always @(negedge clk) begin
    mon(0, ia.out_valid, ia.out_ready, ia.in_ready, ia.bin_out, {4'h0, ia.bcd_out}, ia.ovf, ia.bad_digit);
    mon(1, ib.out_valid, ib.out_ready, ib.in_ready, ib.bin_out, ib.bcd_out, ib.ovf, ib.bad_digit);
  end

  initial begin
    ia.out_ready = 1'b0;
    ib.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ia.out_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
      ib.out_ready = $urandom_range(0, 3) != 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] b;
    drive(0, 1'b0, 1'b0, 16'd0, 10'd0);
    drive(1, 1'b0, 1'b0, 16'd0, 10'd0);
    repeat (2) @(negedge clk);
    rst_chk(0, ia.in_ready, ia.out_valid, ia.bin_out, {4'h0, ia.bcd_out}, ia.ovf, ia.bad_digit);
    rst_chk(1, ib.in_ready, ib.out_valid, ib.bin_out, ib.bcd_out, ib.ovf, ib.bad_digit);
    rst_n = 1'b1;
    send(0, 1'b0, 16'h0999, 10'd0);
    send(1, 1'b0, 16'h1024, 10'd0);
    send(1, 1'b0, 16'h1023, 10'd0);
    send(0, 1'b1, 16'h0000, 10'd255);
    send(0, 1'b1, 16'h0000, 10'd1000);
    send(0, 1'b1, 16'h0000, 10'd1023);
    send(0, 1'b0, 16'h01A3, 10'd0);
    send(1, 1'b1, 16'h0000, 10'd1023);
    // backpressure: result held while out_ready is low, extra in_valid ignored
    wait_idle();
    bp = 1'b1;
    send(0, 1'b0, 16'h0123, 10'd0);
    n = 0;
    while (!ia.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ia.out_valid) fail_now("bp_out_valid_timeout");
    repeat (5) begin
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 16'h0000, 10'd500);
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'd0, 10'd0);
    bp = 1'b0;
    // asynchronous reset in the middle of a conversion
    wait_idle();
    send(0, 1'b1, 16'h0000, 10'd777);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_chk(0, ia.in_ready, ia.out_valid, ia.bin_out, {4'h0, ia.bcd_out}, ia.ovf, ia.bad_digit);
    rst_chk(1, ib.in_ready, ib.out_valid, ib.bin_out, ib.bcd_out, ib.ovf, ib.bad_digit);
    q[0].delete();
    q[1].delete();
    last_bin = '{10'd0, 10'd0};
    last_bcd = '{16'd0, 16'd0};
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("in_ready_post_rst", ia.in_ready, 1);
    send(0, 1'b1, 16'h0000, 10'd999);
    send(0, 1'b0, 16'h0456, 10'd0);
    for (int i = 0; i < 60; i++) begin
      int k;
      logic m;
      k = $urandom_range(0, 1);
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) b = 16'($urandom);
      else for (int j = 0; j < 4; j++) b[4*j +: 4] = 4'($urandom_range(0, 9));
      send(k, m, b, 10'($urandom_range(0, 1023)));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
